// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the FunSel register, its ALU control and the FunSel driver.
package reg_ctrl_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  // Raw codes stay available for legacy code that compares state bits directly.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    CHECK = ST_CHECK
  } state_e;

  function automatic logic is_arith(input logic [1:0] op);
    return (op == FS_DEC) || (op == FS_INC);
  endfunction

endpackage

// File: rtl/reg_funsel_driver.sv
// Sequences E/FunSel/I for one command at a time, tracks the expected register
// value in a shadow copy and flags a sticky mismatch against Q on completion.
module reg_funsel_driver
  import reg_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             e,
  output logic [1:0]       fun_sel,
  output logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] shadow,
  output logic             shadow_valid
);

  state_e           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // mixing in blocking assignments would make the shadow race the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= FS_DEC;
      cnt_q        <= '0;
      e            <= 1'b0;
      fun_sel      <= FS_DEC;
      i            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mismatch     <= 1'b0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q     <= cmd_op;
            fun_sel  <= cmd_op;
            i        <= (cmd_op == FS_LOAD) ? cmd_data : '0;
            cnt_q    <= is_arith(cmd_op) ? cmd_count : CNT_W'(1);
            mismatch <= 1'b0;
            busy     <= 1'b1;
            // A zero-length inc/dec never touches the register.
            if (is_arith(cmd_op) && cmd_count == '0) begin
              state <= CHECK;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              e     <= 1'b1;
            end
          end
        end

        RUN: begin
          unique case (op_q)
            FS_DEC:  shadow <= shadow - WIDTH'(1);
            FS_INC:  shadow <= shadow + WIDTH'(1);
            FS_LOAD: shadow <= i;
            default: shadow <= '0;
          endcase
          if (!is_arith(op_q)) shadow_valid <= 1'b1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= CHECK;
            e     <= 1'b0;
            done  <= 1'b1;
          end
        end

        CHECK: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          if (shadow_valid && (q != shadow)) mismatch <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_funsel_driver.sv
// Drives reg_funsel_driver against a behavioural 16-bit FunSel register with Q
// fed back; a scoreboard queue holds the expected result of every issued command.
module tb_reg_funsel_driver;
  import reg_ctrl_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = FS_DEC;
  logic [CNT_W-1:0] cmd_count = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             e;
  logic [1:0]       fun_sel;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [WIDTH-1:0] shadow;
  logic             shadow_valid;

  logic [WIDTH-1:0] reg_q;
  logic             q_force_en = 1'b0;
  logic [WIDTH-1:0] q_force_val = '0;

  typedef struct {
    logic [WIDTH-1:0] shadow;
    logic             valid;
    logic [WIDTH-1:0] q;
    int               e_cycles;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_shadow = '0;
  logic             m_valid  = 1'b0;

  int errors = 0;
  int checks = 0;
  int e_run = 0;
  int e_total = 0;
  int done_total = 0;

  always #5 clk = ~clk;

  reg_funsel_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_count    (cmd_count),
    .cmd_data     (cmd_data),
    .e            (e),
    .fun_sel      (fun_sel),
    .i            (i),
    .q            (q),
    .busy         (busy),
    .done         (done),
    .mismatch     (mismatch),
    .shadow       (shadow),
    .shadow_valid (shadow_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else if (e) begin
      case (fun_sel)
        FS_DEC:  reg_q <= reg_q - 16'd1;
        FS_INC:  reg_q <= reg_q + 16'd1;
        FS_LOAD: reg_q <= i;
        default: reg_q <= '0;
      endcase
    end
  end

  assign q = q_force_en ? q_force_val : reg_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: counts E-high cycles and scores every Done against the queue head.
  always @(negedge clk) begin
    if (!rst_n) e_run = 0;
    else begin
      if (e) begin
        e_run++;
        e_total++;
      end
      if (done) begin
        done_total++;
        if (sb.size() == 0) check("sb_unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t x;
          x = sb.pop_front();
          check("sb_shadow", 32'(shadow), 32'(x.shadow));
          check("sb_shadow_valid", 32'(shadow_valid), 32'(x.valid));
          check("sb_q", 32'(q), 32'(x.q));
          check("sb_e_cycles", 32'(e_run), 32'(x.e_cycles));
        end
        e_run = 0;
      end
    end
  end

  task automatic push_expected(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                               input logic [WIDTH-1:0] data);
    exp_t x;
    x.e_cycles = 1;
    case (op)
      FS_DEC:  begin m_shadow = m_shadow - 16'(cnt); x.e_cycles = int'(cnt); end
      FS_INC:  begin m_shadow = m_shadow + 16'(cnt); x.e_cycles = int'(cnt); end
      FS_LOAD: begin m_shadow = data; m_valid = 1'b1; end
      default: begin m_shadow = '0;   m_valid = 1'b1; end
    endcase
    x.shadow = m_shadow;
    x.valid  = m_valid;
    x.q      = q_force_en ? q_force_val : m_shadow;
    sb.push_back(x);
  endtask

  // Presents a command and returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                      input logic [WIDTH-1:0] data, input logic hold);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    while (!cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 32'(guard < 1000), 32'd1);
    push_expected(op, cnt, data);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || !cmd_ready) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("idle_timeout", 32'(guard < 2000), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_before;
    int d_before;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_e", 32'(e), 32'd0);
    check("rst_fun_sel", 32'(fun_sel), 32'd0);
    check("rst_i", 32'(i), 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_shadow", 32'(shadow), 32'd0);
    check("rst_shadow_valid", 32'(shadow_valid), 32'd0);
    rst_n = 1'b1;

    // Load with exact cycle-by-cycle latency.
    send(FS_LOAD, 8'd0, 16'h1234, 1'b0);
    check("load_e", 32'(e), 32'd1);
    check("load_fun_sel", 32'(fun_sel), 32'(FS_LOAD));
    check("load_i", 32'(i), 32'h1234);
    check("load_busy", 32'(busy), 32'd1);
    check("load_not_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("load_done", 32'(done), 32'd1);
    check("load_e_off", 32'(e), 32'd0);
    @(posedge clk); #1;
    check("load_ready_again", 32'(cmd_ready), 32'd1);
    check("load_done_off", 32'(done), 32'd0);
    wait_idle();
    check("load_mismatch", 32'(mismatch), 32'd0);

    // Increment across the 0xFFFF boundary.
    send(FS_LOAD, 8'd0, 16'hFFFE, 1'b0);
    send(FS_INC, 8'd3, 16'h0, 1'b0);
    wait_idle();
    check("inc_wrap_shadow", 32'(shadow), 32'h0001);

    // Clear, decrement through zero, then a zero-length decrement.
    send(FS_CLR, 8'd0, 16'h0, 1'b0);
    send(FS_DEC, 8'd1, 16'h0, 1'b0);
    wait_idle();
    check("dec_wrap_shadow", 32'(shadow), 32'hFFFF);
    send(FS_DEC, 8'd0, 16'h0, 1'b0);
    check("dec0_done_next", 32'(done), 32'd1);
    check("dec0_no_e", 32'(e), 32'd0);
    wait_idle();
    check("dec0_unchanged", 32'(q), 32'hFFFF);

    // Forced Q disagrees with the shadow.
    q_force_en  = 1'b1;
    q_force_val = 16'h0011;
    send(FS_LOAD, 8'd0, 16'h0010, 1'b0);
    wait_idle();
    check("mismatch_set", 32'(mismatch), 32'd1);
    q_force_en = 1'b0;
    send(FS_INC, 8'd1, 16'h0, 1'b0);
    check("mismatch_cleared_on_accept", 32'(mismatch), 32'd0);
    wait_idle();
    check("mismatch_stays_clear", 32'(mismatch), 32'd0);

    // Reset in the middle of a long increment.
    send(FS_INC, 8'd200, 16'h0, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_e", 32'(e), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_shadow_valid", 32'(shadow_valid), 32'd0);
    check("midrst_shadow", 32'(shadow), 32'd0);
    sb.delete();
    m_shadow = '0;
    m_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    e_before = e_total;
    repeat (20) @(negedge clk);
    check("midrst_no_e", 32'(e_total - e_before), 32'd0);

    // Before any load/clear no compare happens, even with a disagreeing Q.
    q_force_en  = 1'b1;
    q_force_val = 16'h1234;
    send(FS_DEC, 8'd1, 16'h0, 1'b0);
    wait_idle();
    check("unknown_no_mismatch", 32'(mismatch), 32'd0);
    q_force_en = 1'b0;

    // Back-to-back commands with cmd_valid held high throughout.
    e_before = e_total;
    d_before = done_total;
    send(FS_INC, 8'd3, 16'h0, 1'b1);
    send(FS_DEC, 8'd2, 16'h0, 1'b1);
    send(FS_LOAD, 8'd0, 16'hABCD, 1'b1);
    send(FS_INC, 8'd0, 16'h0, 1'b1);
    send(FS_CLR, 8'd0, 16'h0, 1'b1);
    send(FS_DEC, 8'd5, 16'h0, 1'b0);
    wait_idle();
    check("b2b_e_sum", 32'(e_total - e_before), 32'd12);
    check("b2b_done_count", 32'(done_total - d_before), 32'd6);
    check("b2b_final_q", 32'(q), 32'hFFFB);
    check("b2b_mismatch", 32'(mismatch), 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
